// File: rtl/kuznechik_cipher_param.sv
// Iterative Kuznyechik (GOST R 34.12-2015) encrypt/decrypt core with a writable
// round-key store and L_STEPS LFSR steps of the linear layer per clock.
module kuznechik_cipher_param #(
    parameter int L_STEPS    = 1,
    parameter bit ENABLE_DEC = 1'b1
) (
    input  logic         clk_i,
    input  logic         resetn_i,
    input  logic         request_i,
    input  logic         ack_i,
    input  logic         mode_i,
    input  logic [127:0] data_i,
    input  logic         key_we_i,
    input  logic [3:0]   key_addr_i,
    input  logic [127:0] key_data_i,
    output logic         busy_o,
    output logic         valid_o,
    output logic [127:0] data_o
);

    if (L_STEPS != 1 && L_STEPS != 2 && L_STEPS != 4 && L_STEPS != 8 && L_STEPS != 16) begin : g_bad_l_steps
        $error("kuznechik_cipher_param: L_STEPS must be 1, 2, 4, 8 or 16");
    end

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_KEY  = 3'd1;
    localparam logic [2:0] S_SUB  = 3'd2;
    localparam logic [2:0] S_LIN  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [3:0] CNT_LAST = 4'(16 / L_STEPS - 1);

    // pi table, entry x lives at bits [(255-x)*8 +: 8]
    localparam logic [2047:0] PI = {
        128'hFCEEDD11CF6E3116FBC4FADA23C5044D, 128'hE977F0DB932E99BA1736F1BB14CD5FC1,
        128'hF918655AE25CEF21811C3C428B018E4F, 128'h058402AEE36A8FA0060BED987FD4D31F,
        128'hEB342C51EAC848ABF22A68A2FD3ACECC, 128'hB5700E56080C7612BF7213479CB75D87,
        128'h15A19629107B9AC7F391786F9D9EB2B1, 128'h3275193DFF358A7E6D54C680C3BD0D57,
        128'hDFF524A93EA843C9D779D6F67C22B903, 128'hE00FECDE7A94B0BCDCE828504E330A4A,
        128'hA79760731E0062441AB83882649F2641, 128'hAD454692275E552F8CA3A57D69D5953B,
        128'h0758B34086AC1DF730376BE488D9E789, 128'hE11B83494C3FF8FE8D53AA90CAD88561,
        128'h207167A42D2B095BCB9B25D0BEE56C52, 128'h59A674D2E6F4B4C0D166AFC2394B63B6
    };

    // l() coefficients, a15 first
    localparam logic [127:0] LC = 128'h94_20_85_10_C2_C0_01_FB_01_C0_C2_10_85_20_94_01;

    function automatic logic [2047:0] make_inv(input logic [2047:0] t);
        logic [2047:0] r;
        r = '0;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = t[{~8'(i), 3'b000} +: 8];
            r[{~v, 3'b000} +: 8] = 8'(i);
        end
        return r;
    endfunction

    localparam logic [2047:0] PI_INV = make_inv(PI);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'hC3 : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] l_fn(input logic [127:0] x);
        logic [7:0] acc;
        acc = '0;
        for (int i = 0; i < 16; i++)
            acc = acc ^ gf_mul(x[127-8*i -: 8], LC[127-8*i -: 8]);
        return acc;
    endfunction

    logic [2:0]   state_q, state_d;
    logic [127:0] data_q, data_d;
    logic [127:0] dout_q, dout_d;
    logic         valid_q, valid_d;
    logic         busy_q, busy_d;
    logic         mode_q, mode_d;
    logic [3:0]   idx_q, idx_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] keys_q [10];
    logic         key_wr;

    logic [127:0] sub_fwd, sub_inv, lin_fwd, lin_inv, kx;

    always_comb begin
        sub_fwd = '0;
        for (int b = 0; b < 16; b++)
            sub_fwd[8*b +: 8] = PI[{~data_q[8*b +: 8], 3'b000} +: 8];
    end

    always_comb begin
        lin_fwd = data_q;
        for (int s = 0; s < L_STEPS; s++)
            lin_fwd = {l_fn(lin_fwd), lin_fwd[127:8]};
    end

    if (ENABLE_DEC) begin : g_dec
        always_comb begin
            sub_inv = '0;
            for (int b = 0; b < 16; b++)
                sub_inv[8*b +: 8] = PI_INV[{~data_q[8*b +: 8], 3'b000} +: 8];
        end

        // inverse step: a15..a1 are the old low 15 bytes, a0 the old top byte
        always_comb begin
            lin_inv = data_q;
            for (int s = 0; s < L_STEPS; s++)
                lin_inv = {lin_inv[119:0], l_fn({lin_inv[119:0], lin_inv[127:120]})};
        end
    end else begin : g_nodec
        assign sub_inv = data_q;
        assign lin_inv = data_q;
    end

    assign kx     = data_q ^ keys_q[idx_q];
    assign key_wr = key_we_i && !busy_q && (key_addr_i <= 4'd9);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                // a new request in DONE wins over a simultaneous ack
                if (request_i) begin
                    data_d  = data_i;
                    mode_d  = ENABLE_DEC ? mode_i : 1'b0;
                    idx_d   = (ENABLE_DEC && mode_i) ? 4'd9 : 4'd0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    valid_d = 1'b0;
                    state_d = S_KEY;
                end else if (state_q == S_DONE && ack_i) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_KEY: begin
                data_d = kx;
                if (mode_q ? (idx_q == 4'd0) : (idx_q == 4'd9)) begin
                    dout_d  = kx;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    idx_d   = mode_q ? idx_q - 4'd1 : idx_q + 4'd1;
                    cnt_d   = '0;
                    state_d = mode_q ? S_LIN : S_SUB;
                end
            end
            S_SUB: begin
                data_d  = mode_q ? sub_inv : sub_fwd;
                state_d = mode_q ? S_KEY : S_LIN;
            end
            S_LIN: begin
                data_d = mode_q ? lin_inv : lin_fwd;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = mode_q ? S_SUB : S_KEY;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            mode_q  <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            for (int k = 0; k < 10; k++) keys_q[k] <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            if (key_wr) keys_q[key_addr_i] <= key_data_i;
        end
    end

    assign busy_o  = busy_q;
    assign valid_o = valid_q;
    assign data_o  = dout_q;

endmodule

// File: tb/tb_kuznechik_cipher_param.sv
// Bench for kuznechik_cipher_param: five L_STEPS builds plus an encrypt-only build
// driven in lockstep and compared against a byte-level Kuznyechik model.
module tb_kuznechik_cipher_param;

    localparam int ND = 6;

    logic         clk = 1'b0;
    logic         resetn;
    logic         request, ack, mode;
    logic [127:0] din;
    logic         key_we;
    logic [3:0]   key_addr;
    logic [127:0] key_data;
    logic [ND-1:0] busy, valid;
    logic [127:0] dout [ND];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        kuznechik_cipher_param #(.L_STEPS(1 << g), .ENABLE_DEC(1'b1)) u_dut (
            .clk_i(clk), .resetn_i(resetn), .request_i(request), .ack_i(ack),
            .mode_i(mode), .data_i(din), .key_we_i(key_we), .key_addr_i(key_addr),
            .key_data_i(key_data), .busy_o(busy[g]), .valid_o(valid[g]), .data_o(dout[g]));
    end

    kuznechik_cipher_param #(.L_STEPS(16), .ENABLE_DEC(1'b0)) u_nodec (
        .clk_i(clk), .resetn_i(resetn), .request_i(request), .ack_i(ack),
        .mode_i(mode), .data_i(din), .key_we_i(key_we), .key_addr_i(key_addr),
        .key_data_i(key_data), .busy_o(busy[5]), .valid_o(valid[5]), .data_o(dout[5]));

    int passed = 0;
    int total  = 0;

    logic [7:0]   sb  [256];
    logic [7:0]   sbi [256];
    logic [7:0]   cf  [16] = '{8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
                               8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1};
    logic [127:0] mkeys [10];
    int           first [ND];

    localparam logic [127:0] PT = 128'h1122334455667700ffeeddccbbaa9988;
    localparam logic [127:0] CT = 128'h7f679d90bebc24305a468d42b9d4edcd;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic int lat(input int i);
        return (i < 5) ? 9 * (2 + 16 / (1 << i)) + 1 : 28;
    endfunction

    // carry-less product then polynomial reduction by x^8+x^7+x^6+x+1
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (16'h1C3 << (k - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] model(input bit dec, input logic [127:0] x);
        logic [7:0] b [16];
        logic [7:0] t;
        logic [127:0] r;
        for (int j = 0; j < 16; j++) b[j] = x[127-8*j -: 8];
        if (!dec) begin
            for (int rnd = 0; rnd < 10; rnd++) begin
                for (int j = 0; j < 16; j++) b[j] ^= mkeys[rnd][127-8*j -: 8];
                if (rnd == 9) break;
                for (int j = 0; j < 16; j++) b[j] = sb[b[j]];
                for (int s = 0; s < 16; s++) begin
                    t = '0;
                    for (int j = 0; j < 16; j++) t ^= gmul(cf[j], b[j]);
                    for (int j = 15; j > 0; j--) b[j] = b[j-1];
                    b[0] = t;
                end
            end
        end else begin
            for (int rnd = 9; rnd >= 0; rnd--) begin
                for (int j = 0; j < 16; j++) b[j] ^= mkeys[rnd][127-8*j -: 8];
                if (rnd == 0) break;
                for (int s = 0; s < 16; s++) begin
                    t = '0;
                    for (int j = 0; j < 16; j++) t ^= gmul(cf[j], b[(j+1) % 16]);
                    for (int j = 0; j < 15; j++) b[j] = b[j+1];
                    b[15] = t;
                end
                for (int j = 0; j < 16; j++) b[j] = sbi[b[j]];
            end
        end
        for (int j = 0; j < 16; j++) r[127-8*j -: 8] = b[j];
        return r;
    endfunction

    task automatic write_key(input logic [3:0] a, input logic [127:0] d);
        @(negedge clk);
        key_we = 1'b1; key_addr = a; key_data = d;
        @(negedge clk);
        key_we = 1'b0;
        if (a <= 4'd9) mkeys[a] = d;
    endtask

    // one operation on all DUTs; optional key-write + request poke while busy
    task automatic run_op(input bit m, input logic [127:0] x, input bit with_ack, input int poke);
        logic [127:0] exp_d, exp_e;
        bit busy_ok, all_done;
        exp_d = model(m, x);
        exp_e = model(1'b0, x);
        @(negedge clk);
        request = 1'b1; mode = m; din = x; ack = with_ack;
        @(negedge clk);
        request = 1'b0; ack = 1'b0;
        chk("start_busy_valid", {busy, valid}, {6'h3f, 6'h00});
        for (int i = 0; i < ND; i++) first[i] = 0;
        busy_ok = 1'b1;
        for (int e = 1; e <= 200; e++) begin
            if (poke != 0 && e == poke) begin
                key_we = 1'b1; key_addr = 4'd3; key_data = '1;
                request = 1'b1; mode = ~m; din = {$urandom, $urandom, $urandom, $urandom};
            end else if (poke != 0 && e == poke + 1) begin
                key_we = 1'b0; request = 1'b0;
            end
            @(negedge clk);
            all_done = 1'b1;
            for (int i = 0; i < ND; i++) begin
                if (valid[i] && first[i] == 0) first[i] = e;
                if (first[i] == 0) all_done = 1'b0;
            end
            if (e < lat(0) && !busy[0]) busy_ok = 1'b0;
            if (all_done) break;
        end
        key_we = 1'b0; request = 1'b0;
        chk("busy_window", 128'(busy_ok), 128'd1);
        for (int i = 0; i < ND; i++) begin
            chk($sformatf("latency_dut%0d", i), 128'(first[i]), 128'(lat(i)));
            chk($sformatf("data_dut%0d", i), dout[i], (i < 5) ? exp_d : exp_e);
        end
    endtask

    initial begin
        logic [2047:0] pit;
        logic [127:0] r;
        pit = {
            128'hFCEEDD11CF6E3116FBC4FADA23C5044D, 128'hE977F0DB932E99BA1736F1BB14CD5FC1,
            128'hF918655AE25CEF21811C3C428B018E4F, 128'h058402AEE36A8FA0060BED987FD4D31F,
            128'hEB342C51EAC848ABF22A68A2FD3ACECC, 128'hB5700E56080C7612BF7213479CB75D87,
            128'h15A19629107B9AC7F391786F9D9EB2B1, 128'h3275193DFF358A7E6D54C680C3BD0D57,
            128'hDFF524A93EA843C9D779D6F67C22B903, 128'hE00FECDE7A94B0BCDCE828504E330A4A,
            128'hA79760731E0062441AB83882649F2641, 128'hAD454692275E552F8CA3A57D69D5953B,
            128'h0758B34086AC1DF730376BE488D9E789, 128'hE11B83494C3FF8FE8D53AA90CAD88561,
            128'h207167A42D2B095BCB9B25D0BEE56C52, 128'h59A674D2E6F4B4C0D166AFC2394B63B6};
        for (int i = 0; i < 256; i++) begin
            sb[i] = pit[2047-8*i -: 8];
            sbi[sb[i]] = 8'(i);
        end
        for (int k = 0; k < 10; k++) mkeys[k] = '0;

        resetn = 1'b0; request = 1'b0; ack = 1'b0; mode = 1'b0; din = '0;
        key_we = 1'b0; key_addr = '0; key_data = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy_valid", {busy, valid}, 128'd0);
        chk("reset_data0", dout[0], 128'd0);
        chk("reset_data5", dout[5], 128'd0);
        resetn = 1'b1;

        write_key(4'd0, 128'h8899aabbccddeeff0011223344556677);
        write_key(4'd1, 128'hfedcba98765432100123456789abcdef);
        write_key(4'd2, 128'hdb31485315694343228d6aef8cc78c44);
        write_key(4'd3, 128'h3d4553d8e9cfec6815ebadc40a9ffd04);
        write_key(4'd4, 128'h57646468c44a5e28d3e59246f429f1ac);
        write_key(4'd5, 128'hbd079435165c6432b532e82834da581b);
        write_key(4'd6, 128'h51e640757e8745de705727265a0098b1);
        write_key(4'd7, 128'h5a7925017b9fdd3ed72a91a22286f984);
        write_key(4'd8, 128'hbb44e25378c73123a5f32f73cdb6e517);
        write_key(4'd9, 128'h72e9dd7416bcf45b755dbaa88e4a4043);

        run_op(1'b0, PT, 1'b0, 0);
        chk("std_encrypt_l1", dout[0], CT);
        chk("std_encrypt_l16", dout[4], CT);

        run_op(1'b1, CT, 1'b0, 0);
        chk("std_decrypt_l1", dout[0], PT);
        chk("std_decrypt_l8", dout[3], PT);

        @(negedge clk); ack = 1'b1;
        @(negedge clk); ack = 1'b0;
        chk("ack_valid_low", {busy, valid}, 128'd0);
        chk("ack_data_held", dout[0], PT);

        for (int n = 0; n < 3; n++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            run_op(1'($urandom_range(1)), r, 1'b0, 0);
        end

        run_op(1'b0, PT, 1'b0, 0);
        run_op(1'b1, CT, 1'b1, 0);
        chk("b2b_result", dout[2], PT);

        run_op(1'b0, PT, 1'b0, 5);
        chk("busy_poke_result", dout[0], CT);

        write_key(4'd12, '1);
        run_op(1'b0, PT, 1'b0, 0);
        chk("addr12_ignored", dout[1], CT);

        @(negedge clk);
        request = 1'b1; mode = 1'b0; din = PT;
        @(negedge clk);
        request = 1'b0;
        repeat (5) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("midop_reset_busy_valid", {busy, valid}, 128'd0);
        chk("midop_reset_data0", dout[0], 128'd0);
        chk("midop_reset_data4", dout[4], 128'd0);
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < 10; k++) mkeys[k] = '0;
        r = {$urandom, $urandom, $urandom, $urandom};
        run_op(1'b0, r, 1'b0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/kuznechik_cipher_param.md
Name: kuznechik_cipher_param

Overview:
- Iterative GOST R 34.12-2015 (Kuznyechik) block cipher core. Performs both encryption and decryption on one datapath.
- Round keys come from a host-writable key store. The L/L^-1 transform processes a parametrised number of LFSR steps per clock.
- Sits between the bus-side request/ack controller and the cipher data buffers. It replaces the fixed-key, encrypt-only, 1-step-per-cycle core.

Parameters:
- L_STEPS, 1: R-steps of L (or L^-1) done per clock. Legal values are 1, 2, 4, 8, 16; any other value is a simulation $error at elaboration.
- ENABLE_DEC, 1: 1 builds the inverse S-box and inverse L logic. 0 forces every operation to encrypt and ignores mode_i.

Ports:
- clk_i  in  1  clock
- resetn_i  in  1  reset, asynchronous, active-low
- request_i  in  1  start operation on data_i
- ack_i  in  1  consumer accepted data_o
- mode_i  in  1  0 = encrypt, 1 = decrypt; sampled with request_i
- data_i  in  128  input block; byte 0 of the block is data_i[127:120]
- key_we_i  in  1  round-key write strobe
- key_addr_i  in  4  round-key index 0..9; 10..15 ignored
- key_data_i  in  128  round key K(addr+1)
- busy_o  out  1  computation in progress
- valid_o  out  1  data_o holds a fresh result
- data_o  out  128  result block

Behaviour:
- Reset (async, resetn_i=0):
  - state=IDLE; busy_o=0, valid_o=0, data_o=0.
  - All 10 key-store entries cleared to 0; round index cleared.
- States: IDLE, KEY, SUB, LIN, DONE.
- Key store:
  - A write occurs on a rising edge with key_we_i=1, busy_o=0 and key_addr_i<=9.
  - Writes are ignored while busy_o=1.
- Start:
  - In IDLE or DONE, request_i=1 latches data_i, latches mode (forced to 0 if ENABLE_DEC=0) and sets the round index.
  - Index starts at 0 for encrypt and 9 for decrypt.
  - Same edge: busy_o<=1, valid_o<=0, state<=KEY.
  - request_i is ignored while busy_o=1.
- KEY:
  - data^=K[idx]. Encrypt: idx++. Decrypt: idx--.
  - If this is the last key (idx 9 for encrypt, idx 0 for decrypt): data_o<=result, valid_o<=1, busy_o<=0, state<=DONE.
  - Otherwise: encrypt goes to SUB, decrypt goes to LIN.
- SUB:
  - Encrypt applies pi to all 16 bytes, then goes to LIN.
  - Decrypt applies pi^-1, then goes to KEY.
- LIN:
  - Lasts 16/L_STEPS cycles, counted by a step counter.
  - Each cycle applies L_STEPS R-steps combinationally.
  - Linear function: l(a15..a0) = 148a15^32a14^133a13^16a12^194a11^192a10^a9^251a8^a7^192a6^194a5^16a4^133a3^32a2^148a1^a0, over GF(2^8) mod x^8+x^7+x^6+x+1. Here a15 = data[127:120].
  - Forward step: data <= {l(data), data[127:8]}.
  - Inverse step: data <= {data[119:0], l(data[119:0], data[127:120])}, where data[119:112] is a15 and data[127:120] is a0.
  - After the last LIN cycle: encrypt goes to KEY, decrypt goes to SUB.
- Latency:
  - valid_o rises at rising edge number 9*(2+16/L_STEPS)+1 after the edge that samples request_i.
  - Values: 163 (L_STEPS=1), 55 (4), 28 (16).
  - Encrypt and decrypt have the same latency.
- DONE:
  - valid_o=1 and data_o is held stable.
  - ack_i=1: valid_o<=0, state<=IDLE.
  - request_i=1: starts a new operation as described under Start. If ack_i is asserted in the same cycle, request_i wins (the ack is implied).
- data_o changes only at completion or reset. After ack it holds the last result.
- Reset asserted mid-operation: immediate abort to reset values. The key store must be reloaded afterwards.

Test Plan:
- Load K0..K9 = 8899aabbccddeeff0011223344556677, fedcba98765432100123456789abcdef, db31485315694343228d6aef8cc78c44, 3d4553d8e9cfec6815ebadc40a9ffd04, 57646468c44a5e28d3e59246f429f1ac, bd079435165c6432b532e82834da581b, 51e640757e8745de705727265a0098b1, 5a7925017b9fdd3ed72a91a22286f984, bb44e25378c73123a5f32f73cdb6e517, 72e9dd7416bcf45b755dbaa88e4a4043.
- Then encrypt 1122334455667700ffeeddccbbaa9988 with L_STEPS=1 -> valid_o at edge 163; data_o=7f679d90bebc24305a468d42b9d4edcd; busy_o=1 for edges 1..162.
- Decrypt 7f679d90bebc24305a468d42b9d4edcd with mode_i=1 -> data_o=1122334455667700ffeeddccbbaa9988 at edge 163. With ENABLE_DEC=0 the same stimulus instead yields encryption of that block.
- Repeat the encrypt and decrypt vectors with L_STEPS=2, 4, 8, 16 -> identical data_o. valid_o at edges 91, 55, 37, 28 respectively.
- Back-to-back: in DONE, assert request_i, ack_i, mode_i=1 and data_i=7f67...edcd together -> valid_o=0 and busy_o=1 on the next edge; the second result is 1122...9988.
- While busy: key_we_i to addr 3 with all-ones, and request_i with new data -> both ignored; the result is still 7f67...edcd. A write to addr 12 while idle -> no key changes.
- Pull resetn_i low mid-LIN without a clock edge -> busy_o, valid_o and data_o read 0 immediately. After release, encrypt without reloading keys -> result equals encryption with all-zero keys, consistent with the reference model.
